// File: rtl/multi_adder_datapath.sv
// Multi-cycle chunked add/sub: CHUNK bits per cycle, LSB slice first, carry chained between slices.
// Define DATAPATH_ACCUM_EN to add a WIDTH-bit accumulator (op 10 accumulate, op 11 clear).
module multi_adder_datapath #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             cin_q, carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH:0]   result_q;
  logic             busy_q, done_q, ovf_q;
`ifdef DATAPATH_ACCUM_EN
  logic [WIDTH-1:0] acc_q;
  logic             accum_q;
`endif

  // Effective operands: subtraction is folded into an add of ~b with carry-in forced to 1.
  logic [WIDTH-1:0] opa_d, opb_d;
  logic             cin_d, clear_op;
  always_comb begin
    opa_d    = a;
    opb_d    = b;
    cin_d    = cin;
    clear_op = 1'b0;
`ifdef DATAPATH_ACCUM_EN
    case (op)
      2'b01: begin
        opb_d = ~b;
        cin_d = 1'b1;
      end
      2'b10: begin
        opa_d = acc_q;
        opb_d = a;
      end
      2'b11: clear_op = 1'b1;
      default: ;
    endcase
`else
    if (op[0]) begin
      opb_d = ~b;
      cin_d = 1'b1;
    end
`endif
  end

  int             base;
  logic           slice_cin;
  logic [CHUNK:0] slice_sum;
  logic [WIDTH:0] result_d;
  logic           ovf_d;
  always_comb begin
    base      = int'(idx_q) * CHUNK;
    slice_cin = (idx_q == '0) ? cin_q : carry_q;
    slice_sum = {1'b0, opa_q[base +: CHUNK]} + {1'b0, opb_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, slice_cin};
    result_d  = result_q;
    result_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
    if (idx_q == LAST) result_d[WIDTH] = slice_sum[CHUNK];
    ovf_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (result_d[WIDTH-1] != opa_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef DATAPATH_ACCUM_EN
      acc_q    <= '0;
      accum_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (load) begin
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cin_q    <= cin_d;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
`ifdef DATAPATH_ACCUM_EN
            accum_q  <= (op == 2'b10);
            if (clear_op) acc_q <= '0;
`endif
            if (clear_op) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= slice_sum[CHUNK];
          idx_q    <= idx_q + IW'(1);
          if (idx_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ovf_q   <= ovf_d;
`ifdef DATAPATH_ACCUM_EN
            if (accum_q) acc_q <= result_d[WIDTH-1:0];
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_multi_adder_datapath.sv
// Self-checking bench for multi_adder_datapath (WIDTH=8, CHUNK=4); reference model is plain integer arithmetic.
module tb_multi_adder_datapath;
  localparam int W = 8;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk, rst_n, load, cin;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [W:0]   result;
  logic         busy, done, overflow;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] acc_m = '0;

  multi_adder_datapath #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .op(op), .a(a), .b(b), .cin(cin),
    .result(result), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Expected result/overflow/latency (negedges from load edge to done) from signed/unsigned integer sums.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, y, input logic c,
                                output logic [W:0] r, output logic ov, output int lat);
    longint u;
    int s, sx, sy;
    logic [1:0] eo;
    eo = o;
`ifndef DATAPATH_ACCUM_EN
    if (o == 2'b10) eo = 2'b00;
    else if (o == 2'b11) eo = 2'b01;
`endif
    sx  = $signed(x);
    sy  = $signed(y);
    lat = N + 1;
    case (eo)
      2'b00: begin u = longint'(x) + longint'(y) + longint'(c); s = sx + sy + int'(c); end
      2'b01: begin u = longint'(x) - longint'(y) + (longint'(1) << W); s = sx - sy; end
      2'b10: begin
        u = longint'(acc_m) + longint'(x) + longint'(c);
        s = int'($signed(acc_m)) + sx + int'(c);
        acc_m = u[W-1:0];
      end
      default: begin u = 0; s = 0; acc_m = '0; lat = 1; end
    endcase
    r  = u[W:0];
    ov = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, y, input logic c,
                       output logic [W:0] r, output logic ov, output int lat, output int bcnt);
    @(negedge clk);
    load = 1'b1; op = o; a = x; b = y; cin = c;
    @(posedge clk);
    lat = 0; bcnt = 0; r = 'x; ov = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        load = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 2'($urandom);
      end
      if (busy) bcnt++;
      if (done) begin
        lat = i; r = result; ov = overflow;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (result !== '0) begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if ({busy, done, overflow} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got=%b exp=000", {busy, done, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    logic [W:0] r; logic ov; int lat, bc;
    do_op(2'b00, 8'h7F, 8'h01, 1'b0, r, ov, lat, bc);
    checks++; if (r !== 9'h080 || ov !== 1'b1) begin fails++; $display("FAIL add_ovf got=%h/%b exp=080/1", r, ov); end
    checks++; if (lat !== N + 1) begin fails++; $display("FAIL add_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if (bc !== N) begin fails++; $display("FAIL add_busy got=%0d exp=%0d", bc, N); end
    do_op(2'b00, 8'hFF, 8'h01, 1'b1, r, ov, lat, bc);
    checks++; if (r !== 9'h101 || ov !== 1'b0) begin fails++; $display("FAIL add_carry got=%h/%b exp=101/0", r, ov); end
  endtask

  task automatic test_sub;
    logic [W:0] r; logic ov; int lat, bc;
    do_op(2'b01, 8'h05, 8'h07, 1'b1, r, ov, lat, bc);
    checks++; if (r !== 9'h0FE || ov !== 1'b0) begin fails++; $display("FAIL sub_borrow got=%h/%b exp=0FE/0", r, ov); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] seen;
    logic [W:0] r2, r5;
    @(negedge clk);
    load = 1'b1; op = 2'b00; a = 8'h10; b = 8'h20; cin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen[i] = done;
      if (i == 2) r2 = result;
      if (i == 5) r5 = result;
      // Disturb b only on edges where a capture would be wrong.
      b = (i == 0 || i == 3) ? 8'h77 : 8'h20;
    end
    load = 1'b0;
    checks++; if (seen !== 6'b100100) begin fails++; $display("FAIL b2b_done_pattern got=%b exp=100100", seen); end
    checks++; if (r2 !== 9'h030 || r5 !== 9'h030) begin
      fails++; $display("FAIL b2b_result got=%h,%h exp=030,030", r2, r5);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [W:0] r; logic ov; int lat, bc; logic seen;
    @(negedge clk);
    load = 1'b1; op = 2'b00; a = 8'h33; b = 8'h44; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midreset_clear got=%h busy=%b done=%b exp=000 0 0", result, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL midreset_idle got=activity exp=none"); end
    do_op(2'b00, 8'h33, 8'h44, 1'b0, r, ov, lat, bc);
    checks++; if (r !== 9'h077 || lat !== N + 1) begin
      fails++; $display("FAIL midreset_recover got=%h lat=%0d exp=077 lat=%0d", r, lat, N + 1);
    end
  endtask

  task automatic test_accum;
    logic [W:0] r, er; logic ov, eov; int lat, bc, elat;
    logic [W:0] exp_seq [3];
`ifdef DATAPATH_ACCUM_EN
    exp_seq = '{9'h010, 9'h020, 9'h030};
`else
    exp_seq = '{9'h010, 9'h010, 9'h010};
`endif
    model(2'b11, 8'h00, 8'h00, 1'b0, er, eov, elat);
    do_op(2'b11, 8'h00, 8'h00, 1'b0, r, ov, lat, bc);
    checks++; if (r !== er || lat !== elat) begin
      fails++; $display("FAIL accum_clear got=%h lat=%0d exp=%h lat=%0d", r, lat, er, elat);
    end
    for (int k = 0; k < 3; k++) begin
      model(2'b10, 8'h10, 8'h00, 1'b0, er, eov, elat);
      do_op(2'b10, 8'h10, 8'h00, 1'b0, r, ov, lat, bc);
      checks++; if (r !== exp_seq[k]) begin fails++; $display("FAIL accum_step%0d got=%h exp=%h", k, r, exp_seq[k]); end
    end
  endtask

  task automatic test_random;
    logic [W:0] r, er; logic ov, eov; int lat, bc, elat;
    logic [1:0] o; logic [W-1:0] x, y; logic c;
    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom); x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      model(o, x, y, c, er, eov, elat);
      do_op(o, x, y, c, r, ov, lat, bc);
      checks++; if (r !== er || ov !== eov) begin
        fails++; $display("FAIL rand%0d op=%b a=%h b=%h cin=%b got=%h/%b exp=%h/%b", k, o, x, y, c, r, ov, er, eov);
      end
      checks++; if (lat !== elat || bc !== elat - 1) begin
        fails++; $display("FAIL rand%0d_timing got lat=%0d busy=%0d exp lat=%0d busy=%0d", k, lat, bc, elat, elat - 1);
      end
      @(negedge clk);
      checks++; if (result !== er || done !== 1'b0) begin
        fails++; $display("FAIL rand%0d_hold got=%h done=%b exp=%h done=0", k, result, done, er);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; load = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_op();
    test_accum();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/multi_adder_datapath.md
MULTI_ADDER_DATAPATH -- requirements
Module: multi_adder_datapath

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk is the only clock, and rst_n resets the block immediately when low.
REQ-002 Parameter WIDTH, default 8: operand width in bits, 4..32.
REQ-003 Parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load  input  1  start request, sampled on clk rising edge.
REQ-007 op  input  2  operation: 00 add, 01 sub, 10 accumulate, 11 clear accumulator.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 cin  input  1  carry-in for add and accumulate.
REQ-010 result  output  WIDTH+1  registered result; MSB is the carry-out.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 overflow  output  1  signed two's-complement overflow of the last operation.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE; N = WIDTH/CHUNK.
REQ-015 In IDLE or DONE, load=1 at an edge SHALL capture op, a, b and cin.
REQ-016 That same edge SHALL clear result, zero the chunk index and carry, and enter RUN (op 11 goes directly to DONE).
REQ-017 In RUN, each edge SHALL add one CHUNK slice, LSB slice first, with the carry chained between slices.
REQ-018 Each slice sum SHALL be written into the matching result bits.
REQ-019 The edge that processes slice N-1 SHALL write result[WIDTH] = final carry and update overflow, then enter DONE.
REQ-020 done SHALL be 1 for exactly the cycle spent in DONE.
REQ-021 Latency: load is sampled at edge k; done is high in the cycle after edge k+N.
REQ-022 busy SHALL be 1 from edge k until edge k+N, covering the RUN state only.
REQ-023 DONE SHALL move to IDLE at the next edge unless load=1, in which case the new operation starts with no idle bubble.
REQ-024 load while in RUN SHALL be ignored, and the captured operands SHALL be unaffected.
REQ-025 Sub SHALL compute a + ~b + 1 and ignore cin; result[WIDTH]=1 means no borrow.
REQ-026 overflow SHALL be 1 when the MSBs of both effective operands are equal and differ from the MSB of the sum.
REQ-027 result and overflow SHALL hold their value until the next operation captures.
REQ-028 A change on a, b or cin during RUN SHALL have no effect.
REQ-029 Operands wider than WIDTH do not exist; every sum is exact in WIDTH+1 bits, with no saturation.

Reset
REQ-030 While rst_n=0: FSM in IDLE, result=0, busy=0, done=0, overflow=0, accumulator=0, chunk index=0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block waits in IDLE for load.
REQ-032 Reset release SHALL take effect at the first clk edge after rst_n rises.

Configuration
REQ-033 Macro DATAPATH_ACCUM_EN SHALL compile in a WIDTH-bit accumulator register.
REQ-034 With DATAPATH_ACCUM_EN, op 10 SHALL compute acc + a + cin, with b ignored.
REQ-035 With DATAPATH_ACCUM_EN, an accumulate SHALL write the low WIDTH bits of its result to acc on the edge entering DONE.
REQ-036 With DATAPATH_ACCUM_EN, op 11 SHALL zero acc and result, reach DONE one edge after load and pulse done.
REQ-037 Without DATAPATH_ACCUM_EN, there SHALL be no accumulator flops; op 10 behaves as add and op 11 behaves as sub.

Verification (WIDTH=8, CHUNK=4)
REQ-038 Add: load op=00, a=0x7F, b=0x01, cin=0 -> done 2 cycles after the load edge, result=0x080, overflow=1, busy high for 2 cycles.
REQ-039 Add with carry: a=0xFF, b=0x01, cin=1 -> result=0x101, overflow=0.
REQ-040 Sub: a=0x05, b=0x07 -> result=0x0FE (MSB 0 = borrow), overflow=0.
REQ-041 Back-to-back and ignore: load held high for 6 cycles with a=0x10, b=0x20, op=00 -> done pulses every 3rd cycle, result=0x030, and loads during RUN are ignored.
REQ-042 Reset mid-op: rst_n low one cycle after load -> result=0, busy=0, no done pulse; the next load completes normally.
REQ-043 Accumulate (DATAPATH_ACCUM_EN defined): op=11, then three op=10 with a=0x10, cin=0 -> results 0x010, 0x020, 0x030; with the macro undefined the same sequence yields result=0x010 each time.
